reg4_write_queue: RTL
=====================

# reg4_write_queue

Buffered four-register write stage that sits directly downstream of the 4-way load demultiplexer. It accepts write requests (2-bit register select plus data) over a valid/ready handshake, queues them in a small FIFO, and retires one per cycle by decoding the select into a one-hot load for one of four WIDTH-bit registers. A combinational read port exposes any register's current contents. It decouples bursty producers from the register bank and lets the bank be stalled without losing writes.

## Interface
- WIDTH, 16, data width of each register and of the write data.
- DEPTH, 4, FIFO entries; power of two, ≥ 2.
- clk  input  1  sole clock; all state updates on rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- in_valid  input  1  write request present.
- in_ready  output  1  queue can accept a request this cycle.
- in_addr  input  2  target register select (00→r0, 01→r1, 10→r2, 11→r3).
- in_data  input  WIDTH  write data.
- drain_en  input  1  when 1, head entry is retired this cycle; when 0, queue holds.
- raddr  input  2  read register select.
- rdata  output  WIDTH  contents of selected register (combinational).
- count  output  $clog2(DEPTH)+1  current number of queued entries.
- busy  output  1  count != 0.

## Operation
- Storage: DEPTH-entry circular FIFO of {addr[1:0], data[WIDTH-1:0]}; write pointer, read pointer ($clog2(DEPTH) bits, wrap modulo DEPTH), occupancy counter 0..DEPTH.
- Push: in_valid && in_ready; entry written at write pointer, pointer increments with wrap.
- in_ready = (count < DEPTH); depends only on registered state, never on in_valid or drain_en (no pass-through when full).
- Pop: drain_en && count != 0; head entry retired: its addr decoded one-hot (00→load r0, 01→r1, 10→r2, 11→r3), exactly that register takes head data; read pointer increments with wrap.
- drain_en with count == 0: no effect; no register loads.
- Simultaneous push and pop: both happen; count unchanged. Allowed at any count 1..DEPTH-1; at count == DEPTH push is blocked, pop proceeds.
- Same-address writes retire strictly in arrival order; last one wins.
- rdata = r[raddr] from the register bank (queued entries not visible unless forwarding enabled, see Configuration).
- Requests with in_valid high while in_ready low are ignored; producer must hold them.

## Timing
- Reset (rst_n low, asynchronous): r0..r3 = 0, pointers = 0, count = 0, busy = 0, in_ready = 1, rdata = 0. Reset mid-operation discards all queued entries; registers already loaded are also cleared.
- First rising edge after rst_n deasserts is a normal operating edge.
- Latency: request accepted at edge t is retired at earliest edge t+1 (drain_en high); rdata reflects it after edge t+1. Sustained throughput 1 write/cycle with drain_en held high.
- count/busy/in_ready update on the edge of the push/pop, visible the cycle after.
- Full: count == DEPTH ⇒ in_ready = 0 until a pop edge.

## Configuration
- REG4Q_FWD_EN defined: rdata forwards the youngest queued entry whose addr == raddr, if any; otherwise r[raddr]. Read-after-write then visible in the cycle after acceptance, regardless of drain_en.
- REG4Q_FWD_EN undefined: rdata = r[raddr] only; no FIFO search logic is built.

## Test plan
- Reset: assert rst_n=0 mid-burst with 3 queued entries → immediately count=0, busy=0, in_ready=1, rdata=0 for all raddr.
- Decode: drain_en=1, push (00,0x1111),(01,0x2222),(10,0x3333),(11,0x4444) back-to-back → after 5th edge raddr 0..3 read 0x1111,0x2222,0x3333,0x4444; count returns to 0.
- Full/stall: drain_en=0, push DEPTH=4 entries → count=4, in_ready=0, 5th request held; raise drain_en → 5th accepted on the following edge, all 5 retire in order.
- Ordering: drain_en=0, push (10,0xAAAA) then (10,0xBBBB); release → r2 reads 0xAAAA after first pop edge, 0xBBBB after second.
- Simultaneous push/pop at count=2 → count stays 2, pointers wrap correctly over 8 cycles, data order preserved.
- Forwarding (REG4Q_FWD_EN): drain_en=0, push (01,0x5A5A) → next cycle raddr=01 reads 0x5A5A; without macro reads 0 until drained.

Source files
------------

// File: rtl/reg4_write_queue.sv
// Purpose  : queued write stage for a bank of four WIDTH-bit registers; FIFO
//            entries {addr, data} retire one per cycle into a one-hot register load.
// Latency  : request accepted at edge t retires at edge t+1 at the earliest; rdata follows after the retire edge.
// Backpress: in_ready = (count < DEPTH) from registered state only; drain_en low holds the queue.
//
// Ports:
//   clk, rst_n        - clock, asynchronous active-low reset
//   in_valid/in_ready - write request handshake
//   in_addr, in_data  - target register select and write data
//   drain_en          - allow the head entry to retire this cycle
//   raddr, rdata      - combinational register read port
//   count, busy       - queue occupancy, and (count != 0)
//
// Build option:
//   REG4Q_FWD_EN - when defined, rdata returns the youngest queued entry that
//                  targets raddr. Otherwise rdata shows the register bank only.

module reg4_write_queue #(
  parameter int WIDTH = 16,
  parameter int DEPTH = 4
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic [1:0]              in_addr,
  input  logic [WIDTH-1:0]        in_data,
  input  logic                    drain_en,
  input  logic [1:0]              raddr,
  output logic [WIDTH-1:0]        rdata,
  output logic [$clog2(DEPTH):0]  count,
  output logic                    busy
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  localparam logic [PW-1:0] PTR_ONE  = PW'(1);
  localparam logic [CW-1:0] CNT_ONE  = CW'(1);
  localparam logic [CW-1:0] CNT_FULL = CW'(DEPTH);

  // ---------------------------------------------------------------------------
  // State
  // ---------------------------------------------------------------------------
  logic [1:0]       r_q_addr [DEPTH];
  logic [WIDTH-1:0] r_q_data [DEPTH];
  logic [PW-1:0]    r_wr_ptr;
  logic [PW-1:0]    r_rd_ptr;
  logic [CW-1:0]    r_count;
  logic [WIDTH-1:0] r_bank   [4];

  // ---------------------------------------------------------------------------
  // Handshake and retire decisions
  // ---------------------------------------------------------------------------
  logic             w_in_ready;
  logic             w_push;
  logic             w_pop;
  logic [1:0]       w_head_addr;
  logic [WIDTH-1:0] w_head_data;
  logic [3:0]       w_load;
  logic [WIDTH-1:0] w_bank_rdata;

  // Full blocks the push even if a pop happens on the same edge. This keeps
  // in_ready free of any path from drain_en.
  assign w_in_ready  = (r_count < CNT_FULL);
  assign w_push      = in_valid && w_in_ready;
  assign w_pop       = drain_en && (r_count != '0);

  assign w_head_addr = r_q_addr[r_rd_ptr];
  assign w_head_data = r_q_data[r_rd_ptr];

  // One-hot register load from the head entry's select.
  always_comb begin
    w_load = 4'b0000;
    if (w_pop) begin
      w_load[w_head_addr] = 1'b1;
    end
  end

  // ---------------------------------------------------------------------------
  // FIFO storage. No reset is needed: entries are only observed below r_count.
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (w_push) begin
      r_q_addr[r_wr_ptr] <= in_addr;
      r_q_data[r_wr_ptr] <= in_data;
    end
  end

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) begin
        r_wr_ptr <= r_wr_ptr + PTR_ONE;
      end
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + PTR_ONE;
      end
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + CNT_ONE;
        2'b01:   r_count <= r_count - CNT_ONE;
        default: r_count <= r_count;
      endcase
    end
  end

  // ---------------------------------------------------------------------------
  // Register bank
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int k = 0; k < 4; k++) begin
        r_bank[k] <= '0;
      end
    end else begin
      for (int k = 0; k < 4; k++) begin
        if (w_load[k]) begin
          r_bank[k] <= w_head_data;
        end
      end
    end
  end

  assign w_bank_rdata = r_bank[raddr];

  // ---------------------------------------------------------------------------
  // Read port
  // ---------------------------------------------------------------------------
`ifdef REG4Q_FWD_EN
  logic             w_fwd_hit;
  logic [WIDTH-1:0] w_fwd_data;
  logic [PW-1:0]    w_fwd_idx;

  // Scan from the oldest entry to the youngest. A later match overrides an
  // earlier one, so the youngest queued write to raddr wins.
  always_comb begin
    w_fwd_hit  = 1'b0;
    w_fwd_data = '0;
    w_fwd_idx  = '0;
    for (int i = 0; i < DEPTH; i++) begin
      w_fwd_idx = r_rd_ptr + PW'(i);
      if ((CW'(i) < r_count) && (r_q_addr[w_fwd_idx] == raddr)) begin
        w_fwd_hit  = 1'b1;
        w_fwd_data = r_q_data[w_fwd_idx];
      end
    end
  end

  assign rdata = w_fwd_hit ? w_fwd_data : w_bank_rdata;
`else
  assign rdata = w_bank_rdata;
`endif

  // ---------------------------------------------------------------------------
  // Status
  // ---------------------------------------------------------------------------
  assign in_ready = w_in_ready;
  assign count    = r_count;
  assign busy     = (r_count != '0);

endmodule
